// File: rtl/sha256_stream_hasher.sv
// Streaming SHA-256 front end: packs byte beats into 512-bit blocks and drives sha256_core_v3.
// Define SHA256_HW_PAD_EN to append the 0x80 marker and bit length in hardware (PAD state).
module sha256_core_v3 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first_run,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] hash
);
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [0:7][31:0]  chain;
    logic [0:7][31:0]  wv;
    logic [0:7][31:0]  wv_nxt;
    logic [0:15][31:0] w;
    logic [5:0]        rnd;
    logic              running;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [31:0]       w_new;

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One compression round per cycle over a sliding 16-word schedule window
    always_comb begin
        t1 = wv[7] + (ror(wv[4], 6) ^ ror(wv[4], 11) ^ ror(wv[4], 25))
           + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[rnd] + w[0];
        t2 = (ror(wv[0], 2) ^ ror(wv[0], 13) ^ ror(wv[0], 22))
           + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        wv_nxt = {t1 + t2, wv[0], wv[1], wv[2], wv[3] + t1, wv[4], wv[5], wv[6]};
        w_new = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain   <= '0;
            wv      <= '0;
            w       <= '0;
            rnd     <= '0;
            running <= 1'b0;
            ready   <= 1'b0;
        end else if (start) begin
            chain   <= first_run ? IV : chain;
            wv      <= first_run ? IV : chain;
            w       <= block;
            rnd     <= '0;
            running <= 1'b1;
            ready   <= 1'b0;
        end else if (running) begin
            wv  <= wv_nxt;
            w   <= {w[1:15], w_new};
            rnd <= rnd + 6'd1;
            if (rnd == 6'd63) begin
                running <= 1'b0;
                ready   <= 1'b1;
                for (int i = 0; i < 8; i++) chain[i] <= chain[i] + wv_nxt[i];
            end
        end
    end

    assign hash = chain;
endmodule

module sha256_stream_hasher #(
    parameter int unsigned BYTES_PER_BEAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [8*BYTES_PER_BEAT-1:0] s_data,
    input  logic [BYTES_PER_BEAT-1:0]   s_keep,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [255:0]                hash_out,
    output logic                        hash_valid,
    output logic                        busy
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, PAD = 3'd2, HASH = 3'd3, DONE = 3'd4} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [511:0] blk;
    logic [6:0]   idx;
    logic         final_blk;
    logic         pad_pend;
    logic         first_blk;
    logic         ready_q;
    logic         core_start;
    logic         core_ready;
    logic [255:0] core_hash;
    logic         fire_c;
    logic         hash_done_c;
    logic [6:0]   pop_c;
    logic [6:0]   idx_sum_c;
`ifdef SHA256_HW_PAD_EN
    logic [60:0]  byte_cnt;
    logic         pad_done;
`endif

    sha256_core_v3 u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .first_run (first_blk),
        .block     (blk),
        .ready     (core_ready),
        .hash      (core_hash)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (fire_c) begin
`ifdef SHA256_HW_PAD_EN
                    if (s_last) state_nxt = PAD;
`else
                    if (s_last) state_nxt = HASH;
`endif
                    else if (idx_sum_c == 7'd64) state_nxt = HASH;
                end
            end
            PAD:  state_nxt = HASH;
            HASH: if (hash_done_c) state_nxt = final_blk ? DONE : (pad_pend ? PAD : LOAD);
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake, byte count and core completion (entry cycle masked so a stale high ready is ignored)
    always_comb begin
        fire_c = s_valid & s_ready;
        pop_c  = '0;
        for (int i = 0; i < int'(BYTES_PER_BEAT); i++) pop_c = pop_c + 7'(s_keep[i]);
        idx_sum_c   = idx + pop_c;
        hash_done_c = (state == HASH) & ~core_start & core_ready & ~ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            blk        <= '0;
            idx        <= '0;
            final_blk  <= 1'b0;
            pad_pend   <= 1'b0;
            first_blk  <= 1'b0;
            ready_q    <= 1'b0;
            core_start <= 1'b0;
`ifdef SHA256_HW_PAD_EN
            byte_cnt   <= '0;
            pad_done   <= 1'b0;
`endif
        end else begin
            ready_q    <= core_ready;
            s_ready    <= (state_nxt == LOAD);
            busy       <= !(state_nxt == IDLE || state_nxt == DONE);
            core_start <= (state_nxt == HASH) && (state != HASH);
            if (state_nxt == LOAD && state != LOAD) begin
                blk <= '0;
                idx <= '0;
                if (state == IDLE || state == DONE) begin
                    hash_valid <= 1'b0;
                    first_blk  <= 1'b1;
                    final_blk  <= 1'b0;
                    pad_pend   <= 1'b0;
`ifdef SHA256_HW_PAD_EN
                    byte_cnt   <= '0;
                    pad_done   <= 1'b0;
`endif
                end
            end
            if (fire_c) begin
                for (int j = 0; j < int'(BYTES_PER_BEAT); j++) begin
                    if (s_keep[int'(BYTES_PER_BEAT) - 1 - j] && (int'(idx) + j) < 64)
                        blk[8*(63 - (int'(idx) + j)) +: 8] <= s_data[8*(int'(BYTES_PER_BEAT) - 1 - j) +: 8];
                end
                idx      <= idx_sum_c;
                pad_pend <= 1'b0;
`ifdef SHA256_HW_PAD_EN
                byte_cnt  <= byte_cnt + 61'(pop_c);
                final_blk <= 1'b0;
`else
                final_blk <= s_last;
`endif
            end
`ifdef SHA256_HW_PAD_EN
            // A full last block defers the 0x80 marker to the following block
            if (state == PAD) begin
                if (pad_done) begin
                    blk[63:0] <= {byte_cnt, 3'b000};
                    final_blk <= 1'b1;
                    pad_pend  <= 1'b0;
                end else begin
                    if (idx < 7'd64) begin
                        blk[8*(63 - int'(idx)) +: 8] <= 8'h80;
                        pad_done <= 1'b1;
                    end
                    if (idx < 7'd56) begin
                        blk[63:0] <= {byte_cnt, 3'b000};
                        final_blk <= 1'b1;
                        pad_pend  <= 1'b0;
                    end else begin
                        final_blk <= 1'b0;
                        pad_pend  <= 1'b1;
                    end
                end
            end
`endif
            if (hash_done_c) begin
                hash_out  <= core_hash;
                first_blk <= 1'b0;
                blk       <= '0;
                idx       <= '0;
                if (final_blk) hash_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Directed bench for sha256_stream_hasher: BYTES_PER_BEAT=1 and =4 instances, known SHA-256 digests.
// With SHA256_HW_PAD_EN undefined the bench pre-pads messages itself.
module tb_sha256_stream_hasher;
    logic         clk = 1'b0;
    logic         rst;
    logic         start1, start4;
    logic [7:0]   d1;
    logic [0:0]   k1;
    logic         v1, l1, r1, hv1, b1;
    logic [255:0] h1;
    logic [31:0]  d4;
    logic [3:0]   k4;
    logic         v4, l4, r4, hv4, b4;
    logic [255:0] h4;
    logic [7:0]   msg [0:127];
    int           n_checks = 0;
    int           n_errors = 0;
    int           len;

`ifdef SHA256_HW_PAD_EN
    localparam bit HW_PAD = 1'b1;
`else
    localparam bit HW_PAD = 1'b0;
`endif
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    always #5 clk = ~clk;

    sha256_stream_hasher #(.BYTES_PER_BEAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_data(d1), .s_keep(k1), .s_valid(v1),
        .s_last(l1), .s_ready(r1), .hash_out(h1), .hash_valid(hv1), .busy(b1));

    sha256_stream_hasher #(.BYTES_PER_BEAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .s_data(d4), .s_keep(k4), .s_valid(v4),
        .s_last(l4), .s_ready(r4), .hash_out(h4), .hash_valid(hv4), .busy(b4));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int sel); return (sel == 1) ? r1 : r4; endfunction
    function automatic logic get_busy(input int sel); return (sel == 1) ? b1 : b4; endfunction
    function automatic logic get_hv(input int sel); return (sel == 1) ? hv1 : hv4; endfunction
    function automatic logic [255:0] get_hash(input int sel); return (sel == 1) ? h1 : h4; endfunction

    task automatic set_in(input int sel, input logic [31:0] d, input logic [3:0] k, input logic v, input logic l);
        if (sel == 1) begin
            d1 = d[31:24]; k1 = k[3]; v1 = v; l1 = l;
        end else begin
            d4 = d; k4 = k; v4 = v; l4 = l;
        end
    endtask

    // Loads msg from a string; without hardware padding, appends 0x80, zeros and the bit length
    task automatic fill(input string s, output int n);
        for (int i = 0; i < 128; i++) msg[i] = 8'h00;
        n = s.len();
        for (int i = 0; i < n; i++) msg[i] = s[i];
        if (!HW_PAD) begin
            int plen;
            logic [63:0] bits;
            plen = ((n + 8) / 64 + 1) * 64;
            bits = 64'(n) * 64'd8;
            msg[n] = 8'h80;
            for (int i = 0; i < 8; i++) msg[plen - 8 + i] = bits[63 - 8*i -: 8];
            n = plen;
        end
    endtask

    task automatic send_beat(input int sel, input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        set_in(sel, d, k, 1'b1, l);
        while (!get_ready(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("beat_ready_timeout", get_ready(sel), 1'b1);
        @(negedge clk);
        set_in(sel, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic send_msg(input int sel, input int n);
        if (sel == 1) begin
            for (int i = 0; i < n; i++) send_beat(1, {msg[i], 24'h0}, 4'b1000, i == n - 1);
        end else begin
            int nb;
            logic [31:0] d;
            logic [3:0] k;
            nb = (n == 0) ? 1 : (n + 3) / 4;
            for (int b = 0; b < nb; b++) begin
                d = '0;
                k = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4*b + j < n) begin
                        d[31 - 8*j -: 8] = msg[4*b + j];
                        k[3 - j] = 1'b1;
                    end
                end
                send_beat(4, d, k, b == nb - 1);
            end
        end
    endtask

    task automatic start_msg(input int sel, input string tag);
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        check({tag, "_start_ready"}, get_ready(sel), 1'b1);
        check({tag, "_start_busy"}, get_busy(sel), 1'b1);
        check({tag, "_start_hv"}, get_hv(sel), 1'b0);
    endtask

    task automatic wait_hash(input int sel, input string tag);
        int n;
        n = 0;
        while (!get_hv(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_hash_valid"}, get_hv(sel), 1'b1);
    endtask

    task automatic run_msg(input int sel, input string tag, input string s, input logic [255:0] exp);
        int n;
        fill(s, n);
        start_msg(sel, tag);
        send_msg(sel, n);
        wait_hash(sel, tag);
        check({tag, "_digest"}, get_hash(sel), exp);
        check({tag, "_busy_done"}, get_busy(sel), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        set_in(1, 32'h0, 4'h0, 1'b0, 1'b0);
        set_in(4, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready1", r1, 1'b0);
        check("reset_busy1", b1, 1'b0);
        check("reset_hv1", hv1, 1'b0);
        check("reset_hash1", h1, 256'h0);
        check("reset_ready4", r4, 1'b0);
        check("reset_busy4", b4, 1'b0);
        check("reset_hv4", hv4, 1'b0);
        check("reset_hash4", h4, 256'h0);

        run_msg(1, "abc_b1", "abc", D_ABC);
        repeat (20) @(negedge clk);
        check("abc_b1_hold_hash", h1, D_ABC);
        check("abc_b1_hold_hv", hv1, 1'b1);

        run_msg(4, "abc_b4", "abc", D_ABC);
        run_msg(4, "empty_b4", "", D_EMPTY);
        run_msg(1, "two_blk_b1", "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", D_56);

        // Start during hashing is ignored; reset then aborts the in-flight block
        fill("abc", len);
        start_msg(4, "abort");
        send_msg(4, len);
        repeat (10) @(negedge clk);
        check("abort_busy_hash", b4, 1'b1);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("ignored_start_ready", r4, 1'b0);
        check("ignored_start_busy", b4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", r4, 1'b0);
        check("abort_busy", b4, 1'b0);
        check("abort_hv", hv4, 1'b0);
        check("abort_hash", h4, 256'h0);

        run_msg(4, "abc_after_rst", "abc", D_ABC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
